// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V integer datapath.
//   XLEN     : data width of one integer register
//   AW       : register address width
//   NREG     : number of architectural registers (x0 included)
//   ZERO_REG : address of the hardwired-zero register x0
//   word_t   : one XLEN-bit data word
//   addr_t   : one register address
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   addr_t;

  localparam addr_t ZERO_REG = 5'd0;

endpackage : riscv_pkg

// File: rtl/reg_file_rd_if.sv
// Bus bundle between the datapath controller and the register file.
//   we/wa/wd     : write port (write-back stage)
//   re/ra1/ra2   : read strobe and the two source addresses
//   rd1/rd2      : registered A/B operands
//   rvalid       : operands captured at the previous edge are on rd1/rd2
// Handshake: there is no ready. re is accepted at every rising edge where
// rst is low; rvalid is high for exactly the cycle following that edge and
// rd1/rd2 hold their value until the next accepted re.
interface reg_file_rd_if;
  import riscv_pkg::*;

  logic  we;
  addr_t wa;
  word_t wd;
  logic  re;
  addr_t ra1;
  addr_t ra2;
  word_t rd1;
  word_t rd2;
  logic  rvalid;

  // Controller side
  modport master (
    output we, wa, wd, re, ra1, ra2,
    input  rd1, rd2, rvalid
  );

  // Register file side
  modport slave (
    input  we, wa, wd, re, ra1, ra2,
    output rd1, rd2, rvalid
  );

endinterface : reg_file_rd_if

// File: rtl/reg_cell.sv
// Load-enabled register with synchronous active-high reset.
//   clk : clock
//   rst : synchronous reset, clears the register (wins over sel)
//   sel : load enable
//   in  : data loaded when sel is high
//   out : stored value
module reg_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (sel) begin
      data_d = in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out = data_q;

endmodule : reg_cell

// File: rtl/reg_file_rd.sv
// Integer register file with registered read ports.
// 31 writable registers (x1..x31) plus hardwired x0, one synchronous write
// port and two read ports captured into the A/B operand registers on re.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset; clears storage, operands, rvalid
//   bus : reg_file_rd_if.slave (we/wa/wd, re/ra1/ra2 in; rd1/rd2/rvalid out)
module reg_file_rd
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  reg_file_rd_if.slave  bus
);

  // Entry 0 is a constant zero so the read mux can be indexed directly.
  word_t            ent [NREG];
  logic [NREG-1:1]  wsel;
  word_t            rd1_d;
  word_t            rd2_d;
  word_t            rd1_q;
  word_t            rd2_q;
  logic             rvalid_d;
  logic             rvalid_q;

  // Write decode: no select exists for x0, so writes to it are dropped.
  always_comb begin
    wsel = '0;
    for (int i = 1; i < NREG; i++) begin
      wsel[i] = bus.we && (bus.wa == addr_t'(i));
    end
  end

  assign ent[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_entry
    reg_cell #(.W(XLEN)) u_entry (
      .clk (clk),
      .rst (rst),
      .sel (wsel[g]),
      .in  (bus.wd),
      .out (ent[g])
    );
  end

  // Read value with write-through bypass: a same-edge write to the address
  // being read is forwarded so the new data wins. x0 is never bypassed.
  always_comb begin
    rd1_d = ent[bus.ra1];
    if (bus.ra1 == ZERO_REG) begin
      rd1_d = '0;
    end else if (bus.we && (bus.wa == bus.ra1)) begin
      rd1_d = bus.wd;
    end
  end

  always_comb begin
    rd2_d = ent[bus.ra2];
    if (bus.ra2 == ZERO_REG) begin
      rd2_d = '0;
    end else if (bus.we && (bus.wa == bus.ra2)) begin
      rd2_d = bus.wd;
    end
  end

  // A/B operand registers: loaded only on re, otherwise hold.
  reg_cell #(.W(XLEN)) u_rd1 (
    .clk (clk),
    .rst (rst),
    .sel (bus.re),
    .in  (rd1_d),
    .out (rd1_q)
  );

  reg_cell #(.W(XLEN)) u_rd2 (
    .clk (clk),
    .rst (rst),
    .sel (bus.re),
    .in  (rd2_d),
    .out (rd2_q)
  );

  always_comb begin
    rvalid_d = bus.re;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rd1    = rd1_q;
  assign bus.rd2    = rd2_q;
  assign bus.rvalid = rvalid_q;

endmodule : reg_file_rd

// File: tb/tb_reg_file_rd.sv
// Self-checking bench for reg_file_rd: directed vectors, a behavioural
// model compared every cycle, and hand-computed literal checkpoints.
module tb_reg_file_rd;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  reg_file_rd_if bus_if ();

  reg_file_rd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  word_t m_mem [NREG];
  word_t m_rd1;
  word_t m_rd2;
  logic  m_rv;
  bit    m_init = 1'b0;

  function automatic word_t m_value(input addr_t a);
    if (a == 0) return '0;
    if (bus_if.we && bus_if.wa == a) return bus_if.wd;
    return m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_rd1  = '0;
      m_rd2  = '0;
      m_rv   = 1'b0;
      m_init = 1'b1;
    end else begin
      if (bus_if.re) begin
        m_rd1 = m_value(bus_if.ra1);
        m_rd2 = m_value(bus_if.ra2);
      end
      m_rv = bus_if.re;
      if (bus_if.we && bus_if.wa != 0) m_mem[bus_if.wa] = bus_if.wd;
    end
  end

  // Compare process: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_rd1", bus_if.rd1, m_rd1);
      chk("model_rd2", bus_if.rd2, m_rd2);
      chk("model_rvalid", word_t'(bus_if.rvalid), word_t'(m_rv));
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs just after a falling edge and returns at the
  // next falling edge, i.e. after the rising edge that consumed them.
  task automatic drive(input logic r, input logic w, input addr_t a, input word_t d,
                       input logic e, input addr_t a1, input addr_t a2);
    rst        = r;
    bus_if.we  = w;
    bus_if.wa  = a;
    bus_if.wd  = d;
    bus_if.re  = e;
    bus_if.ra1 = a1;
    bus_if.ra2 = a2;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic wr(input addr_t a, input word_t d);
    drive(1'b0, 1'b1, a, d, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic rd(input addr_t a1, input addr_t a2);
    drive(1'b0, 1'b0, 5'd0, '0, 1'b1, a1, a2);
  endtask

  task automatic lit(input string name, input word_t e1, input word_t e2, input logic ev);
    chk({name, "_rd1"}, bus_if.rd1, e1);
    chk({name, "_rd2"}, bus_if.rd2, e2);
    chk({name, "_rvalid"}, word_t'(bus_if.rvalid), word_t'(ev));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    bus_if.we  = 1'b0;
    bus_if.wa  = '0;
    bus_if.wd  = '0;
    bus_if.re  = 1'b0;
    bus_if.ra1 = '0;
    bus_if.ra2 = '0;
    @(negedge clk);

    // Reset for 2 cycles, then read x5/x31
    drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    lit("reset", 32'h0, 32'h0, 1'b0);
    rd(5'd5, 5'd31);
    lit("first_read", 32'h0, 32'h0, 1'b1);

    // Write x3=6, read back, then hold for 5 idle cycles
    wr(5'd3, 32'h0000_0006);
    lit("after_write", 32'h0, 32'h0, 1'b0);
    rd(5'd3, 5'd0);
    lit("read_x3", 32'h6, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    lit("hold", 32'h6, 32'h0, 1'b0);

    // x0 protection
    wr(5'd0, 32'hDEAD_BEEF);
    rd(5'd0, 5'd0);
    lit("x0", 32'h0, 32'h0, 1'b1);

    // Bypass: x7 holds 3, same-edge write of 9 must win on both ports
    wr(5'd7, 32'd3);
    drive(1'b0, 1'b1, 5'd7, 32'd9, 1'b1, 5'd7, 5'd7);
    lit("bypass", 32'd9, 32'd9, 1'b1);
    rd(5'd7, 5'd3);
    lit("after_bypass", 32'd9, 32'd6, 1'b1);

    // Back-to-back reads of preloaded x1..x3
    wr(5'd1, 32'd10);
    wr(5'd2, 32'd20);
    wr(5'd3, 32'd30);
    rd(5'd1, 5'd3);
    lit("b2b_0", 32'd10, 32'd30, 1'b1);
    rd(5'd2, 5'd2);
    lit("b2b_1", 32'd20, 32'd20, 1'b1);
    rd(5'd3, 5'd1);
    lit("b2b_2", 32'd30, 32'd10, 1'b1);
    idle();
    lit("b2b_end", 32'd30, 32'd10, 1'b0);

    // Reset wins over a same-cycle write; storage is cleared
    drive(1'b1, 1'b1, 5'd4, 32'd5, 1'b1, 5'd4, 5'd4);
    lit("rst_prio", 32'h0, 32'h0, 1'b0);
    rd(5'd4, 5'd3);
    lit("rst_cleared", 32'h0, 32'h0, 1'b1);

    // Reset during an rvalid cycle clears the operands at the next edge
    wr(5'd4, 32'h55);
    rd(5'd4, 5'd4);
    lit("pre_rst", 32'h55, 32'h55, 1'b1);
    drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    lit("mid_rst", 32'h0, 32'h0, 1'b0);

    // Directed sweep: fill every register, then read pairs with a
    // concurrent write to an unrelated register
    for (int i = 0; i < NREG; i++) wr(addr_t'(i), 32'h0101_0101 * i);
    for (int i = 0; i < NREG; i++)
      drive(1'b0, 1'b1, addr_t'((i + 5) % NREG), 32'hA5A5_0000 + i, 1'b1,
            addr_t'(i), addr_t'(NREG - 1 - i));
    rd(5'd31, 5'd30);
    lit("sweep_end", 32'hA5A5_001A, 32'hA5A5_0019, 1'b1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_rd

// File: doc/reg_file_rd.md
# reg_file_rd

Integer register file for the multicycle RISC-V datapath: 31 writable 32-bit registers plus hardwired x0. One synchronous write port fed by the write-back stage, and two registered read ports that capture rs1/rs2 into the A/B operand registers on a read strobe. Read data is held until the next strobe; `rvalid` marks the cycle the new operands are available to the ALU-stage controller.

## Interface
- `XLEN`, 32: data width.
- `AW`, 5: register address width (2**AW entries, entry 0 hardwired).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we` in 1: write strobe, one write per cycle.
- `wa` in AW: write address.
- `wd` in XLEN: write data.
- `re` in 1: read strobe; captures both read ports.
- `ra1` in AW: rs1 address.
- `ra2` in AW: rs2 address.
- `rd1` out XLEN: registered rs1 data (A register).
- `rd2` out XLEN: registered rs2 data (B register).
- `rvalid` out 1: high for exactly the cycle after an accepted `re`.

## Operation
- Reset (rst=1 at an edge): all entries 1..31 set to 0; `rd1`=`rd2`=0; `rvalid`=0. Reset overrides `we`/`re` in the same cycle; nothing is written or captured.
- Write: `we`=1 at an edge with `wa`≠0 sets entry[wa]←wd. A write with `wa`=0 is discarded silently; x0 always reads 0.
- Read: `re`=1 at an edge sets rd1←value(ra1) and rd2←value(ra2), then `rvalid`=1 for the following cycle.
- value(a): 0 if a=0; else wd if `we`=1 and `wa`=a in the same cycle (write-through bypass, new data wins); else entry[a].
- `re`=0: rd1/rd2 hold their last captured value indefinitely; `rvalid`=0.
- ra1=ra2 is legal; both ports return the same value.
- Back-to-back `re`: every cycle captures independently; `rvalid` stays high continuously.
- No flow control: `re` and `we` are always accepted when rst=0.
- No arithmetic and no width conversion. Addresses are exactly AW bits, so no out-of-range case exists.

## Timing
- Write latency: 1 edge. Data is visible to a read captured at the next edge. The bypass makes a same-edge read see it as well.
- Read latency: 1 edge from `re` to valid `rd1`/`rd2`/`rvalid`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-sequence: if rst asserts in the cycle after `re`, the next edge clears rd1/rd2 and `rvalid`. Stored contents are also cleared. No pending state survives reset.
- First `re` accepted at the first edge with rst=0.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`, `AW`;
  - `ZERO_REG` = 5'd0;
  - a `word_t` typedef for XLEN-bit data.
- Storage: an array of 31 entries, no write for index 0.
- One natural sub-module, `reg_cell`: a load-enabled XLEN register with synchronous reset (inputs clk, rst, sel, in; output out).
  - Instantiated for entries 1..31.
  - Instantiated for the rd1/rd2 capture registers.
- Decode, the bypass muxes and `rvalid` live in the top module.

## Test plan
- Reset then read: rst 1 for 2 cycles, then `re` with ra1=5, ra2=31 → rd1=0, rd2=0, `rvalid`=1 one cycle after `re`.
- Write/read: write wa=3, wd=32'h0000_0006, then `re` ra1=3, ra2=0 next cycle → rd1=6, rd2=0. Drop `re` for 5 cycles → rd1 still 6, `rvalid`=0.
- x0 protection: write wa=0, wd=32'hDEAD_BEEF, then read ra1=0 → rd1=0.
- Bypass: in one cycle, `we` wa=7, wd=9 while `re` ra1=7, ra2=7, with entry 7 previously 3 → rd1=rd2=9.
- Back-to-back reads: `re` for 3 consecutive cycles with ra1=1,2,3 (preloaded 10,20,30) → rd1=10,20,30 on successive cycles, `rvalid` high 3 cycles.
- Reset priority: `we` wa=4, wd=5 with rst=1 in the same cycle, then read ra1=4 → 0. Also assert rst during a `rvalid` cycle → rd1/rd2/`rvalid` are 0 at the next edge.
